encrypt_job_ctrl: RTL and testbench
===================================

# encrypt_job_ctrl

Sequencing and arbitration controller for the iterative 128-bit `encryptor` core. It accepts encryption jobs (plaintext plus key) from two independent requesters and grants the core round-robin. It restarts the core for each job, waits for `done`, then returns the ciphertext on one shared, tagged response channel. It sits between the user-facing request logic and the single `encryptor` instance.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in RUN before a job is aborted (used only with `ENC_TIMEOUT_EN`).
- `DATA_W`, default 128: plaintext, key and ciphertext width; fixed at 128 for the `encryptor` core.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has a job.
- `req0_ready` / `req1_ready`  out  1  job accepted this cycle when ANDed with the matching valid.
- `req0_plaintext`, `req0_key`, `req1_plaintext`, `req1_key`  in  128  job operands.
- `enc_rst`  out  1  active-high restart to the core; loads `enc_plaintext`/`enc_key`.
- `enc_plaintext`, `enc_key`  out  128  registered operands to the core.
- `enc_done`  in  1  core result valid.
- `enc_ciphertext`  in  128  core result.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_id`  out  1  requester index (0 or 1) that owns the response.
- `resp_data`  out  128  ciphertext; all zeros on timeout.
- `resp_err`  out  1  job aborted by timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP. Reset state is IDLE.
- IDLE:
  - Arbiter selects one valid requester. With both valid, it selects the one not served last; `last_grant` resets to 1, so requester 0 wins first.
  - Only the selected requester's ready is driven high.
  - On handshake: latch operands into `enc_plaintext`/`enc_key`, latch `resp_id`, then go to LOAD.
- LOAD: exactly one cycle with `enc_rst`=1; cycle counter cleared; go to RUN.
- RUN:
  - `enc_rst`=0; cycle counter increments every cycle.
  - `enc_done`=1: capture `enc_ciphertext` into `resp_data`, set `resp_err`=0, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES` with no done (macro on only): set `resp_data`=0, `resp_err`=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `resp_valid`=1; `resp_data`, `resp_id` and `resp_err` stay stable until the handshake.
  - On `resp_valid && resp_ready`: update `last_grant` to `resp_id`, go to IDLE.
- Requests are never accepted outside IDLE; both readys are 0 in LOAD, RUN and RESP.
- `enc_done` is ignored outside RUN, including in the LOAD cycle.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
- Reset mid-job (`rst_n` low in any state) takes effect immediately:
  - state=IDLE, job dropped, no response issued;
  - `enc_rst`=1 while reset is asserted, so the core is held in restart.

## Timing
- Reset values:
  - `req*_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `busy`=0;
  - `enc_plaintext`=0, `enc_key`=0;
  - `enc_rst`=1 during reset, 0 in the first IDLE cycle after release.
- Readys are combinational from state, valids and `last_grant`.
- All other outputs are registered.
- Cycle sequence:
  - cycle 0: accept handshake;
  - cycle 1: LOAD (`enc_rst`=1);
  - cycles 2 onward: RUN.
- `enc_done` sampled high in cycle N gives `resp_valid`=1 in cycle N+1.
- Minimum issue-to-issue spacing is 4 cycles. A new acceptance is earliest one cycle after the response handshake.

## Configuration
- `ENC_TIMEOUT_EN` defined: RUN aborts after `TIMEOUT_CYCLES` as specified, with `resp_err` and a zero `resp_data`.
- `ENC_TIMEOUT_EN` undefined:
  - no counter is built; RUN waits indefinitely for `enc_done`;
  - `resp_err` is tied to 0.

## Structure
- Package `encrypt_ctrl_pkg` holds:
  - state enum `enc_state_t` (IDLE, LOAD, RUN, RESP);
  - `ENC_DATA_W`=128;
  - `ENC_NUM_REQ`=2.
- Sub-module `rr_arb2`: combinational two-way round-robin grant from the valids and `last_grant`, producing one-hot readys.
- The top level holds the FSM, operand/result registers and the timeout counter.

## Test plan
- **Core model for all scenarios:** behavioural stub asserting `enc_done` 10 cycles after `enc_rst` falls, with ciphertext = plaintext ^ key.
- **Single job:** req0 sends plaintext `128'h69206c6f766520636f6d706172636821`, key `128'h6d65677361797372617772746f796f75` -> exactly one LOAD pulse; `resp_valid` with `resp_id`=0, `resp_data`=`128'h04450b1c171c5311...` (XOR of the operands), `resp_err`=0.
- **Contention:** both requesters valid continuously for 4 jobs -> grants alternate 0, 1, 0, 1 and never issue back to back without RESP in between.
- **Back-pressure:** `resp_ready` low for 20 cycles -> `resp_valid`, data and id held stable; no ready asserted to either requester.
- **Timeout (macro on, `TIMEOUT_CYCLES`=64):** stub never asserts done -> `resp_err`=1, `resp_data`=0 on cycle 64 of RUN; the next job completes normally.
- **Reset mid-RUN:** `rst_n` low for 2 cycles at RUN cycle 5 -> all outputs at reset values; `enc_rst`=1 while low; no response issued; a new job after release succeeds.
- **Done/timeout collision:** stub asserts done exactly at cycle `TIMEOUT_CYCLES` -> `resp_err`=0 with the valid ciphertext.

Source files
------------

// File: rtl/encrypt_ctrl_pkg.sv
// encrypt_ctrl_pkg
//   Shared definitions for the encryptor job controller.
//   - enc_state_t : controller FSM states (IDLE, LOAD, RUN, RESP)
//   - ENC_DATA_W  : plaintext / key / ciphertext width of the encryptor core
//   - ENC_NUM_REQ : number of requesters served by the arbiter
package encrypt_ctrl_pkg;

    localparam int ENC_DATA_W  = 128;
    localparam int ENC_NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } enc_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin arbiter.
//   Ports:
//     enable     in  1  arbitration allowed (controller idle)
//     valid      in  2  request valids, bit i = requester i
//     last_grant in  1  index of the requester served last
//     grant      out 2  one-hot grant (all zero when disabled or no request)
module rr_arb2 (
    input  logic       enable,
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid[0] && valid[1]) begin
                // Both asking: serve the one that did not go last.
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                // At most one bit set here, so the valids are already one-hot.
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/encrypt_job_ctrl.sv
// encrypt_job_ctrl
//   Sequencing and arbitration controller for the iterative 128-bit encryptor
//   core. Two requesters submit (plaintext, key) jobs; they are granted
//   round-robin, the core is restarted with the operands, and the result is
//   returned on one tagged response channel.
//
//   Optional feature: define ENC_TIMEOUT_EN to build the RUN timeout counter.
//   Without it RUN waits for enc_done indefinitely and resp_err is tied to 0.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. Requester readys are combinational (state, valids, last grant);
//   resp_valid is registered and, once high, resp_id/resp_data/resp_err hold
//   until resp_ready is seen.
//
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     req0_valid/ready/plaintext/key  requester 0 job channel
//     req1_valid/ready/plaintext/key  requester 1 job channel
//     enc_rst                      restart to the core (high while in reset)
//     enc_plaintext, enc_key       registered operands to the core
//     enc_done, enc_ciphertext     core result
//     resp_valid/ready/id/data/err tagged response channel
//     busy                         controller not idle
//     state                        current FSM state (debug)
module encrypt_job_ctrl
    import encrypt_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_W         = ENC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_plaintext,
    input  logic [DATA_W-1:0] req0_key,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_plaintext,
    input  logic [DATA_W-1:0] req1_key,
    output logic              enc_rst,
    output logic [DATA_W-1:0] enc_plaintext,
    output logic [DATA_W-1:0] enc_key,
    input  logic              enc_done,
    input  logic [DATA_W-1:0] enc_ciphertext,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              busy,
    output logic [1:0]        state
);

    enc_state_t state_q;
    logic       last_grant;
    logic [1:0] valid_vec;
    logic [1:0] grant;
    logic       accept;
    logic       timeout_hit;

    assign state     = state_q;
    assign valid_vec = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .enable     (state_q == ST_IDLE),
        .valid      (valid_vec),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    // A grant is only ever given to a valid requester.
    assign accept     = |grant;

`ifdef ENC_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cycle_cnt;
    logic             err_q;

    // Counts RUN cycles already completed; RUN cycle k sees k-1, so the
    // TIMEOUT_CYCLES-th RUN cycle is the one that aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (state_q == ST_LOAD) begin
            cycle_cnt <= '0;
        end else if (state_q == ST_RUN && cycle_cnt != CNT_MAX) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_RUN) && (cycle_cnt >= CNT_LAST);
    assign resp_err    = err_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant    <= 1'b1;
            enc_rst       <= 1'b1;
            enc_plaintext <= '0;
            enc_key       <= '0;
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_data     <= '0;
            busy          <= 1'b0;
`ifdef ENC_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            enc_rst <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        enc_plaintext <= grant[1] ? req1_plaintext : req0_plaintext;
                        enc_key       <= grant[1] ? req1_key : req0_key;
                        resp_id       <= grant[1];
                        enc_rst       <= 1'b1;
                        busy          <= 1'b1;
                        state_q       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    // Done has priority over a timeout in the same cycle.
                    if (enc_done) begin
                        resp_data  <= enc_ciphertext;
                        resp_valid <= 1'b1;
                        state_q    <= ST_RESP;
`ifdef ENC_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end else if (timeout_hit) begin
                        resp_data  <= '0;
                        resp_valid <= 1'b1;
                        state_q    <= ST_RESP;
`ifdef ENC_TIMEOUT_EN
                        err_q      <= 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        last_grant <= resp_id;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_job_ctrl.sv
// tb_encrypt_job_ctrl
//   Directed bench for encrypt_job_ctrl with a behavioural core stub
//   (done N cycles after restart, ciphertext = plaintext ^ key) and a
//   job-level model checked against the DUT on every falling edge.
module tb_encrypt_job_ctrl;

    localparam int TIMEOUT = 64;
    localparam logic [127:0] PT1  = 128'h69206c6f766520636f6d706172636821;
    localparam logic [127:0] KEY1 = 128'h6d65677361797372617772746f796f75;
    localparam logic [127:0] CT1  = 128'h04450b1c171c53110e1a02151d1a0754;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_plaintext, req0_key, req1_plaintext, req1_key;
    logic         enc_rst, enc_done;
    logic [127:0] enc_plaintext, enc_key, enc_ciphertext;
    logic         resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [127:0] resp_data;
    logic [1:0]   dbg_state;

    encrypt_job_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .DATA_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_plaintext(req0_plaintext), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_plaintext(req1_plaintext), .req1_key(req1_key),
        .enc_rst(enc_rst), .enc_plaintext(enc_plaintext), .enc_key(enc_key),
        .enc_done(enc_done), .enc_ciphertext(enc_ciphertext),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
        .state(dbg_state)
    );

    // ---------------- core stub ----------------
    // done_delay > 0: done from the done_delay-th cycle after restart drops
    // done_delay = 0: never done; done_delay < 0: done stuck high
    int done_delay;
    int low_cnt;
    always @(posedge clk) low_cnt <= enc_rst ? 0 : low_cnt + 1;
    assign enc_done = (done_delay < 0) ? 1'b1 :
                      ((done_delay > 0) && !enc_rst && (low_cnt + 1 >= done_delay));
    assign enc_ciphertext = enc_plaintext ^ enc_key;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected responses: {id, err, data}
    logic [129:0] exp_q[$];

    // job-level model state
    logic         m_active, m_resp, m_last, m_id;
    int           m_cyc;
    logic [127:0] m_pt, m_key;
    logic         after_rst, exp_r0, exp_r1;

    // observations of the DUT for literal checks
    int   cyc = 0;
    logic took0 = 1'b0, took1 = 1'b0;
    logic prev_rv = 1'b0;
    int   dut_accept_cyc, dut_resp_cyc;
    int   accept_log[$];
    int   grant_log[$];
    int   load_pulses = 0, resp_count = 0, rise_count = 0, held_cycles = 0;
    logic         last_id, last_err;
    logic [127:0] last_data;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_enc_pt", enc_plaintext, 0);
            chk("rst_enc_key", enc_key, 0);
            chk("rst_enc_rst", enc_rst, 1);
            m_active = 0; m_resp = 0; m_last = 1; m_id = 0; m_cyc = 0;
            m_pt = '0; m_key = '0;
            exp_q.delete();
            after_rst = 1;
            took0 = 0; took1 = 0; prev_rv = 0;
        end else begin
            // arbitration rule: only when idle; with both asking, not-last wins
            exp_r0 = 0; exp_r1 = 0;
            if (!m_active) begin
                if (req0_valid && req1_valid) begin
                    exp_r0 = m_last;
                    exp_r1 = !m_last;
                end else begin
                    exp_r0 = req0_valid;
                    exp_r1 = req1_valid;
                end
            end
            chk("req0_ready", req0_ready, exp_r0);
            chk("req1_ready", req1_ready, exp_r1);
            chk("busy", busy, m_active);
            chk("resp_valid", resp_valid, m_resp);
            chk("enc_plaintext", enc_plaintext, m_pt);
            chk("enc_key", enc_key, m_key);
            if (!after_rst) begin
                chk("enc_rst", enc_rst, m_active && m_cyc == 1);
                if (enc_rst) load_pulses++;
            end
            if (m_resp) begin
                chk("resp_id", resp_id, exp_q[0][129]);
                chk("resp_err", resp_err, exp_q[0][128]);
                chk("resp_data", resp_data, exp_q[0][127:0]);
            end

            // DUT observations
            took0 = req0_valid && req0_ready;
            took1 = req1_valid && req1_ready;
            if (took0 || took1) begin
                dut_accept_cyc = cyc;
                accept_log.push_back(cyc);
                grant_log.push_back(took1 ? 1 : 0);
            end
            if (resp_valid && !prev_rv) begin
                dut_resp_cyc = cyc;
                rise_count++;
            end
            if (resp_valid && !resp_ready) held_cycles++;
            if (resp_valid && resp_ready) begin
                resp_count++;
                last_id = resp_id; last_err = resp_err; last_data = resp_data;
            end
            prev_rv = resp_valid;

            // advance the model to the next cycle
            if (!m_active) begin
                if ((exp_r0 && req0_valid) || (exp_r1 && req1_valid)) begin
                    m_id     = exp_r1;
                    m_pt     = exp_r1 ? req1_plaintext : req0_plaintext;
                    m_key    = exp_r1 ? req1_key : req0_key;
                    m_active = 1;
                    m_cyc    = 1;
                end
            end else if (m_resp) begin
                if (resp_ready) begin
                    m_last = m_id;
                    void'(exp_q.pop_front());
                    m_active = 0;
                    m_resp   = 0;
                end
            end else begin
                // m_cyc: 1 = LOAD, k+1 = RUN cycle k
                if (m_cyc >= 2 && enc_done) begin
                    exp_q.push_back({m_id, 1'b0, enc_ciphertext});
                    m_resp = 1;
`ifdef ENC_TIMEOUT_EN
                end else if (m_cyc - 1 == TIMEOUT) begin
                    exp_q.push_back({m_id, 1'b1, 128'h0});
                    m_resp = 1;
`endif
                end
                m_cyc++;
            end
            after_rst = 0;
        end
    end

    // ---------------- driver tasks ----------------
    logic [255:0] q0[$];
    logic [255:0] q1[$];

    task automatic drive();
        req0_valid     = (q0.size() > 0);
        req0_plaintext = req0_valid ? q0[0][255:128] : '0;
        req0_key       = req0_valid ? q0[0][127:0] : '0;
        req1_valid     = (q1.size() > 0);
        req1_plaintext = req1_valid ? q1[0][255:128] : '0;
        req1_key       = req1_valid ? q1[0][127:0] : '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (took0) void'(q0.pop_front());
        if (took1) void'(q1.pop_front());
        drive();
    endtask

    task automatic enq(input int id, input logic [127:0] pt, input logic [127:0] key);
        if (id == 0) q0.push_back({pt, key});
        else         q1.push_back({pt, key});
        drive();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !m_active && !took0 && !took1)) begin
            if (n >= budget) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_done: jobs still pending after %0d cycles", budget);
                return;
            end
            step();
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    int base_i, base_lp, base_rc, base_rise, base_held, n;

    initial begin
        rst_n = 1'b1;
        resp_ready = 1'b1;
        done_delay = 10;
        req0_valid = 0; req1_valid = 0;
        req0_plaintext = '0; req0_key = '0; req1_plaintext = '0; req1_key = '0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // single job: accept cycle 0, LOAD 1, done in RUN cycle 10 (cycle 11)
        base_lp = load_pulses;
        enq(0, PT1, KEY1);
        wait_done(100);
        chk("single_latency", dut_resp_cyc - dut_accept_cyc, 12);
        chk("single_data", last_data, CT1);
        chk("single_id", last_id, 0);
        chk("single_err", last_err, 0);
        chk("single_load_pulses", load_pulses - base_lp, 1);

        // contention: both valid for 4 jobs, fresh reset so 0 wins first
        do_reset(2);
        base_i = grant_log.size();
        enq(0, 128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100);
        enq(1, 128'hdeadbeefcafebabe0123456789abcdef, 128'h13579bdf2468ace0fedcba9876543210);
        enq(0, 128'hffffffffffffffffffffffffffffffff, 128'h00000000000000000000000000000001);
        enq(1, 128'h80000000000000000000000000000000, 128'h80000000000000000000000000000000);
        wait_done(200);
        chk("cont_count", grant_log.size() - base_i, 4);
        if (grant_log.size() - base_i == 4) begin
            chk("cont_grant0", grant_log[base_i + 0], 0);
            chk("cont_grant1", grant_log[base_i + 1], 1);
            chk("cont_grant2", grant_log[base_i + 2], 0);
            chk("cont_grant3", grant_log[base_i + 3], 1);
            for (int i = 1; i < 4; i++)
                chk("cont_spacing", accept_log[base_i + i] - accept_log[base_i + i - 1], 13);
        end

        // back-pressure: hold resp_ready low for 20 cycles, other requester waiting
        base_held = held_cycles;
        resp_ready = 1'b0;
        enq(0, 128'h0123456789abcdef0123456789abcdef, 128'hffeeddccbbaa99887766554433221100);
        enq(1, 128'h1111222233334444555566667777888a, 128'h99990000aaaabbbbccccddddeeeeffff);
        n = 0;
        while (!resp_valid && n < 60) begin
            step();
            n++;
        end
        chk("bp_resp_seen", resp_valid, 1);
        repeat (20) step();
        resp_ready = 1'b1;
        wait_done(100);
        chk("bp_held_cycles", held_cycles - base_held, 20);
        chk("bp_last_id", last_id, 1);

        // done stuck high: ignored in LOAD, taken in RUN cycle 1
        done_delay = -1;
        enq(1, PT1, KEY1);
        wait_done(50);
        chk("stuck_latency", dut_resp_cyc - dut_accept_cyc, 3);
        chk("stuck_data", last_data, CT1);
        chk("stuck_id", last_id, 1);
        done_delay = 10;
        repeat (2) step();

`ifdef ENC_TIMEOUT_EN
        // timeout: abort at RUN cycle 64, response one cycle later
        done_delay = 0;
        enq(0, PT1, KEY1);
        wait_done(150);
        chk("to_latency", dut_resp_cyc - dut_accept_cyc, 66);
        chk("to_err", last_err, 1);
        chk("to_data", last_data, 0);
        done_delay = 10;
        enq(1, PT1, KEY1);
        wait_done(100);
        chk("after_to_latency", dut_resp_cyc - dut_accept_cyc, 12);
        chk("after_to_err", last_err, 0);
        chk("after_to_data", last_data, CT1);

        // done and timeout in the same cycle: done wins
        done_delay = TIMEOUT;
        enq(0, PT1, KEY1);
        wait_done(150);
        chk("coll_latency", dut_resp_cyc - dut_accept_cyc, 66);
        chk("coll_err", last_err, 0);
        chk("coll_data", last_data, CT1);
        done_delay = 10;
`else
        // no timeout: a job without done waits indefinitely
        done_delay = 0;
        base_rise = rise_count;
        enq(0, PT1, KEY1);
        repeat (100) step();
        chk("nto_no_resp", rise_count - base_rise, 0);
        chk("nto_busy", busy, 1);
        done_delay = 10;
        wait_done(50);
        chk("nto_err", last_err, 0);
        chk("nto_data", last_data, CT1);
`endif

        // reset mid-RUN: job dropped, no response, next job works
        base_rc = resp_count;
        enq(0, 128'hcafef00dcafef00dcafef00dcafef00d, 128'h0badc0de0badc0de0badc0de0badc0de);
        n = 0;
        while (!(m_active && m_cyc == 6) && n < 50) begin
            step();
            n++;
        end
        chk("mid_reached_run5", m_cyc, 6);
        do_reset(2);
        repeat (20) step();
        chk("mid_no_resp", resp_count - base_rc, 0);
        enq(1, PT1, KEY1);
        wait_done(100);
        chk("mid_after_count", resp_count - base_rc, 1);
        chk("mid_after_id", last_id, 1);
        chk("mid_after_data", last_data, CT1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
